// File: rtl/pen_locator.sv
// Light-pen locator: confirms a pen hit on the same pixel over consecutive frames and
// issues one valid/ready frame-RAM write for it. Optional erase input: PEN_LOCATOR_ERASE_EN.
module pen_locator #(
  parameter int CONFIRM_FRAMES = 2,
  parameter int HOLDOFF_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       slot_valid,
  input  logic [2:0] slot_row,
  input  logic [2:0] slot_col,
  input  logic       pen_hit,
`ifdef PEN_LOCATOR_ERASE_EN
  input  logic       erase,
`endif
  input  logic       wr_ready,
  output logic       wr_valid,
  output logic [5:0] wr_addr,
  output logic       wr_data,
  output logic       busy,
  output logic [1:0] fsm_state
);

  // Write port handshake: wr_valid/wr_addr/wr_data are held stable from assertion until the
  // cycle in which wr_valid && wr_ready; only rst may drop wr_valid without that handshake.

  typedef enum logic [1:0] {IDLE, CONFIRM, WRITE, HOLDOFF} state_t;

  localparam logic [3:0] CONFIRM_N = 4'(CONFIRM_FRAMES);
  localparam logic [3:0] HOLD_N    = 4'(HOLDOFF_FRAMES);

  state_t     state, state_nx;
  logic       frame_hit, discard;
  logic [5:0] cand_addr, ref_addr, ref_nx;
  logic [3:0] cnt, cnt_nx, cnt_inc, hcnt, hcnt_nx, hcnt_inc;
  logic       hit_now, handshake;
  logic [5:0] slot_addr;

  assign hit_now   = slot_valid && pen_hit;
  assign slot_addr = {slot_row, slot_col};
  assign handshake = wr_valid && wr_ready;
  assign cnt_inc   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign hcnt_inc  = (hcnt == 4'hF) ? hcnt : hcnt + 4'd1;

  // First hit of each frame; a hit coinciding with frame_start opens the new frame.
  // Frames that overlap a pending write are thrown away until the next frame_start after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_hit <= 1'b0;
      cand_addr <= 6'd0;
      discard   <= 1'b0;
    end else if (state == WRITE) begin
      frame_hit <= 1'b0;
      discard   <= 1'b1;
    end else if (frame_start) begin
      discard   <= 1'b0;
      frame_hit <= hit_now;
      if (hit_now) cand_addr <= slot_addr;
    end else if (hit_now && !frame_hit && !discard) begin
      frame_hit <= 1'b1;
      cand_addr <= slot_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ref_addr <= 6'd0;
      cnt      <= 4'd0;
      hcnt     <= 4'd0;
    end else begin
      state    <= state_nx;
      ref_addr <= ref_nx;
      cnt      <= cnt_nx;
      hcnt     <= hcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ref_nx   = ref_addr;
    cnt_nx   = cnt;
    hcnt_nx  = hcnt;
    unique case (state)
      IDLE: begin
        if (frame_start && frame_hit) begin
          ref_nx   = cand_addr;
          cnt_nx   = 4'd1;
          state_nx = (CONFIRM_N <= 4'd1) ? WRITE : CONFIRM;
        end
      end
      CONFIRM: begin
        if (frame_start) begin
          if (!frame_hit) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end else if (cand_addr != ref_addr) begin
            ref_nx = cand_addr;
            cnt_nx = 4'd1;
          end else begin
            cnt_nx = cnt_inc;
            if (cnt_inc >= CONFIRM_N) state_nx = WRITE;
          end
        end
      end
      WRITE: begin
        if (handshake) begin
          hcnt_nx  = 4'd0;
          cnt_nx   = 4'd0;
          state_nx = (HOLD_N == 4'd0) ? IDLE : HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (frame_start) begin
          hcnt_nx = hcnt_inc;
          if (hcnt_inc >= HOLD_N) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Registered write outputs, loaded on entry to WRITE so they appear one cycle after
  // the confirming frame_start and stay frozen for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= 6'd0;
      wr_data  <= 1'b0;
    end else begin
      wr_valid <= (state_nx == WRITE);
      if (state != WRITE && state_nx == WRITE) begin
        wr_addr <= ref_nx;
`ifdef PEN_LOCATOR_ERASE_EN
        wr_data <= ~erase;
`else
        wr_data <= 1'b1;
`endif
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
